// File: rtl/mem_port_arbiter.sv
// Arbitrates one block-wide memory port between Icache fills and Dcache fills/write-backs.
// Optional grant statistics are built when ARB_STATS_EN is defined.
module mem_port_arbiter #(
  parameter int WORD_SIZE    = 16,
  parameter int BLOCK_SIZE   = 64,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  Clk,
  input  logic                  Reset_N,
  input  logic                  i_readM,
  input  logic [WORD_SIZE-1:0]  i_address,
  output logic [BLOCK_SIZE-1:0] i_rdata,
  output logic                  i_ack,
  input  logic                  d_readM,
  input  logic                  d_writeM,
  input  logic [WORD_SIZE-1:0]  d_address,
  input  logic [BLOCK_SIZE-1:0] d_wdata,
  output logic [BLOCK_SIZE-1:0] d_rdata,
  output logic                  d_ack,
  output logic                  m_readM,
  output logic                  m_writeM,
  output logic [WORD_SIZE-1:0]  m_address,
  output logic [BLOCK_SIZE-1:0] m_wdata,
  input  logic [BLOCK_SIZE-1:0] m_rdata,
  input  logic                  m_done,
  output logic [15:0]           i_grant_cnt,
  output logic [15:0]           d_grant_cnt
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_I_BUSY, S_D_BUSY, S_ACK} state_t;

  state_t                r_state;
  logic [SW-1:0]         r_streak;
  logic                  r_i_ack, r_d_ack;
  logic                  r_m_readM, r_m_writeM;
  logic [WORD_SIZE-1:0]  r_m_address;
  logic [BLOCK_SIZE-1:0] r_m_wdata;
  logic [BLOCK_SIZE-1:0] r_i_rdata, r_d_rdata;

  logic w_d_req, w_grant_d, w_grant_i;

  // Dcache wins unless it has already starved a pending Icache request MAX_D_STREAK times.
  assign w_d_req   = d_readM | d_writeM;
  assign w_grant_d = (r_state == S_IDLE) && w_d_req && (!i_readM || (r_streak != STREAK_MAX));
  assign w_grant_i = (r_state == S_IDLE) && i_readM && !w_grant_d;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state     <= S_IDLE;
      r_streak    <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_m_readM   <= 1'b0;
      r_m_writeM  <= 1'b0;
      r_m_address <= '0;
      r_m_wdata   <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_d) begin
            r_state     <= S_D_BUSY;
            r_m_address <= d_address;
            r_m_wdata   <= d_wdata;
            r_m_writeM  <= d_writeM;
            r_m_readM   <= ~d_writeM;
            if (!i_readM)
              r_streak <= '0;
            else if (r_streak != STREAK_MAX)
              r_streak <= r_streak + SW'(1);
          end else if (w_grant_i) begin
            r_state     <= S_I_BUSY;
            r_m_address <= i_address;
            r_m_readM   <= 1'b1;
            r_m_writeM  <= 1'b0;
            r_streak    <= '0;
          end
        end
        S_I_BUSY: begin
          if (m_done) begin
            r_i_rdata <= m_rdata;
            r_m_readM <= 1'b0;
            r_i_ack   <= 1'b1;
            r_state   <= S_ACK;
          end
        end
        S_D_BUSY: begin
          if (m_done) begin
            // The held write strobe marks a write-back, whose completion leaves d_rdata alone.
            if (!r_m_writeM)
              r_d_rdata <= m_rdata;
            r_m_readM  <= 1'b0;
            r_m_writeM <= 1'b0;
            r_d_ack    <= 1'b1;
            r_state    <= S_ACK;
          end
        end
        S_ACK:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] r_i_grant_cnt, r_d_grant_cnt;

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_i_grant_cnt <= '0;
      r_d_grant_cnt <= '0;
    end else begin
      if (w_grant_i) r_i_grant_cnt <= r_i_grant_cnt + 16'd1;
      if (w_grant_d) r_d_grant_cnt <= r_d_grant_cnt + 16'd1;
    end
  end

  assign i_grant_cnt = r_i_grant_cnt;
  assign d_grant_cnt = r_d_grant_cnt;
`else
  assign i_grant_cnt = '0;
  assign d_grant_cnt = '0;
`endif

  assign i_ack     = r_i_ack;
  assign d_ack     = r_d_ack;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign m_readM   = r_m_readM;
  assign m_writeM  = r_m_writeM;
  assign m_address = r_m_address;
  assign m_wdata   = r_m_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// checked against a grant/streak/data reference model.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;

  logic        Clk, Reset_N;
  logic        i_readM, d_readM, d_writeM, m_done;
  logic [15:0] i_address, d_address;
  logic [63:0] d_wdata, m_rdata;
  logic [63:0] i_rdata, d_rdata, m_wdata;
  logic        i_ack, d_ack, m_readM, m_writeM;
  logic [15:0] m_address, i_grant_cnt, d_grant_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          mdl_streak;
  logic [15:0] mdl_icnt, mdl_dcnt;
  logic [63:0] mdl_irdata, mdl_drdata;

  mem_port_arbiter #(.WORD_SIZE(16), .BLOCK_SIZE(64), .MAX_D_STREAK(MAXS)) dut (
    .Clk(Clk), .Reset_N(Reset_N),
    .i_readM(i_readM), .i_address(i_address), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .m_readM(m_readM), .m_writeM(m_writeM), .m_address(m_address), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_done(m_done),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [15:0] exp_icnt();
`ifdef ARB_STATS_EN
    return mdl_icnt;
`else
    return 16'd0;
`endif
  endfunction

  function automatic logic [15:0] exp_dcnt();
`ifdef ARB_STATS_EN
    return mdl_dcnt;
`else
    return 16'd0;
`endif
  endfunction

  task automatic model_clear();
    mdl_streak = 0;
    mdl_icnt   = '0;
    mdl_dcnt   = '0;
    mdl_irdata = '0;
    mdl_drdata = '0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_N = 1'b0;
    i_readM = 0; d_readM = 0; d_writeM = 0; m_done = 0;
    model_clear();
    repeat (2) @(negedge Clk);
    Reset_N = 1'b1;
    @(negedge Clk);
  endtask

  // Serves one transaction from IDLE with current request levels; memory answers lat cycles after strobe.
  task automatic serve(input int lat, input logic [63:0] rd, output bit got_d);
    bit          ireq, dreq, exp_d, exp_w;
    logic [15:0] exp_addr;
    logic [63:0] exp_wd;
    int          n;
    ireq = i_readM;
    dreq = d_readM | d_writeM;
    exp_d = dreq && (!ireq || mdl_streak < MAXS);
    if (exp_d) mdl_streak = ireq ? ((mdl_streak < MAXS) ? mdl_streak + 1 : MAXS) : 0;
    else       mdl_streak = 0;
    exp_w    = exp_d && d_writeM;
    exp_addr = exp_d ? d_address : i_address;
    exp_wd   = d_wdata;
    if (exp_d) mdl_dcnt = mdl_dcnt + 16'd1; else mdl_icnt = mdl_icnt + 16'd1;

    n = 1;
    @(negedge Clk);
    while (!(m_readM | m_writeM) && n < 20) begin @(negedge Clk); n++; end
    checks++; if (n != 1) begin errors++; $display("FAIL strobe_latency: got %0d cycles expected 1", n); end
    checks++; if (m_address !== exp_addr) begin errors++; $display("FAIL m_address: got %h expected %h", m_address, exp_addr); end
    checks++; if ({m_writeM, m_readM} !== (exp_w ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL strobe_kind: got w%b r%b expected write=%0d", m_writeM, m_readM, exp_w); end
    if (exp_w) begin
      checks++; if (m_wdata !== exp_wd) begin errors++; $display("FAIL m_wdata: got %h expected %h", m_wdata, exp_wd); end
    end
    checks++; if ({i_grant_cnt, d_grant_cnt} !== {exp_icnt(), exp_dcnt()}) begin
      errors++; $display("FAIL grant_cnt: got %0d/%0d expected %0d/%0d", i_grant_cnt, d_grant_cnt, exp_icnt(), exp_dcnt()); end

    repeat (lat - 1) @(negedge Clk);
    m_rdata = rd;
    m_done  = 1'b1;
    checks++; if ({i_ack, d_ack, m_readM | m_writeM} !== 3'b001) begin
      errors++; $display("FAIL pre_done: got acks %b%b strobe %b expected 0 0 1", i_ack, d_ack, m_readM | m_writeM); end
    @(negedge Clk);
    m_done = 1'b0;
    got_d  = d_ack;
    if (exp_d && !exp_w) mdl_drdata = rd;
    if (!exp_d)          mdl_irdata = rd;
    checks++; if ({i_ack, d_ack} !== (exp_d ? 2'b01 : 2'b10)) begin
      errors++; $display("FAIL ack_side: got i%b d%b expected d_side=%0d", i_ack, d_ack, exp_d); end
    checks++; if ({m_readM, m_writeM} !== 2'b00) begin
      errors++; $display("FAIL strobe_drop: got r%b w%b expected 0 0", m_readM, m_writeM); end
    checks++; if (i_rdata !== mdl_irdata) begin errors++; $display("FAIL i_rdata: got %h expected %h", i_rdata, mdl_irdata); end
    checks++; if (d_rdata !== mdl_drdata) begin errors++; $display("FAIL d_rdata: got %h expected %h", d_rdata, mdl_drdata); end
    if (exp_d) begin d_readM = 0; d_writeM = 0; end else i_readM = 0;
    @(negedge Clk);
    checks++; if ({i_ack, d_ack} !== 2'b00) begin errors++; $display("FAIL ack_pulse: got i%b d%b expected 0 0", i_ack, d_ack); end
  endtask

  task automatic test_reset();
    Reset_N = 1'b0;
    i_readM = 0; d_readM = 0; d_writeM = 0; m_done = 0;
    i_address = '0; d_address = '0; d_wdata = '0; m_rdata = '0;
    model_clear();
    @(negedge Clk);
    checks++; if ({m_readM, m_writeM, i_ack, d_ack} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {m_readM, m_writeM, i_ack, d_ack}); end
    checks++; if ({m_address, m_wdata, i_rdata, d_rdata} !== '0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h/%h expected 0", m_address, m_wdata, i_rdata, d_rdata); end
    checks++; if ({i_grant_cnt, d_grant_cnt} !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", i_grant_cnt, d_grant_cnt); end
    Reset_N = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_i_only();
    bit g;
    i_readM = 1; i_address = 16'h0040;
    serve(3, 64'h0123_4567_89AB_CDEF, g);
    checks++; if (i_rdata !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL i_only_rdata: got %h expected 0123456789abcdef", i_rdata); end
  endtask

  task automatic test_ignore_done();
    m_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    m_done = 1'b1;
    @(negedge Clk);
    m_done = 1'b0;
    @(negedge Clk);
    checks++; if ({i_ack, d_ack, m_readM, m_writeM} !== 4'b0000) begin
      errors++; $display("FAIL idle_done_ctrl: got %b expected 0000", {i_ack, d_ack, m_readM, m_writeM}); end
    checks++; if (i_rdata !== mdl_irdata || d_rdata !== mdl_drdata) begin
      errors++; $display("FAIL idle_done_data: got %h/%h expected %h/%h", i_rdata, d_rdata, mdl_irdata, mdl_drdata); end
  endtask

  task automatic test_collision();
    bit g;
    do_reset();
    i_readM = 1; i_address = 16'h1111;
    d_readM = 1; d_address = 16'h2222;
    serve(2, {$urandom, $urandom}, g);
    checks++; if (g !== 1'b1) begin errors++; $display("FAIL collision_first: got d_side=%0d expected 1", g); end
    serve(2, {$urandom, $urandom}, g);
    checks++; if (g !== 1'b0) begin errors++; $display("FAIL collision_second: got d_side=%0d expected 0", g); end
  endtask

  task automatic test_starvation();
    bit g;
    bit exp_seq [6] = '{1, 1, 1, 1, 0, 1};
    do_reset();
    i_readM = 1; i_address = 16'h0A00;
    for (int k = 0; k < 6; k++) begin
      d_readM = 1; d_address = 16'h0B00 + 16'(k);
      serve(1 + (k % 3), {$urandom, $urandom}, g);
      checks++; if (g !== exp_seq[k]) begin
        errors++; $display("FAIL starve_seq[%0d]: got d_side=%0d expected %0d", k, g, exp_seq[k]); end
    end
  endtask

  task automatic test_write();
    bit g;
    d_writeM = 1; d_address = 16'h0100; d_wdata = 64'hFFFF_0000_FFFF_0000;
    serve(2, 64'h5555_AAAA_5555_AAAA, g);
    d_readM = 1; d_writeM = 1; d_address = 16'h0180; d_wdata = 64'h1234_0000_5678_0000;
    serve(1, 64'h7777_8888_9999_AAAA, g);
  endtask

  task automatic test_reset_midop();
    bit g;
    int acks;
    d_readM = 1; d_address = 16'h0300;
    @(negedge Clk);
    checks++; if (m_readM !== 1'b1) begin errors++; $display("FAIL midop_busy: got m_readM=%b expected 1", m_readM); end
    Reset_N = 1'b0;
    #1;
    checks++; if ({m_readM, m_writeM, d_ack, d_rdata} !== '0) begin
      errors++; $display("FAIL midop_async: got r%b w%b ack%b rdata %h expected all 0", m_readM, m_writeM, d_ack, d_rdata); end
    model_clear();
    d_readM = 0;
    m_done = 1;
    @(negedge Clk);
    m_done = 0;
    Reset_N = 1'b1;
    acks = 0;
    repeat (3) begin @(negedge Clk); if (d_ack | i_ack | m_readM | m_writeM) acks++; end
    checks++; if (acks != 0) begin errors++; $display("FAIL midop_quiet: got %0d active cycles expected 0", acks); end
    d_readM = 1; d_address = 16'h0304;
    serve(2, {$urandom, $urandom}, g);
  endtask

  task automatic test_stats();
    bit g;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin i_readM = 1; i_address = 16'h4000 + 16'(k); end
      else       begin d_readM = 1; d_address = 16'h5000 + 16'(k); end
      serve(1, {$urandom, $urandom}, g);
    end
`ifdef ARB_STATS_EN
    checks++; if ({i_grant_cnt, d_grant_cnt} !== {16'd3, 16'd2}) begin
      errors++; $display("FAIL stats_final: got %0d/%0d expected 3/2", i_grant_cnt, d_grant_cnt); end
`else
    checks++; if ({i_grant_cnt, d_grant_cnt} !== 32'd0) begin
      errors++; $display("FAIL stats_final: got %0d/%0d expected 0/0", i_grant_cnt, d_grant_cnt); end
`endif
  endtask

  task automatic test_random();
    bit g;
    for (int k = 0; k < 60; k++) begin
      if (!i_readM && $urandom_range(1, 0) == 1) begin
        i_readM = 1; i_address = 16'($urandom);
      end
      if (!(d_readM | d_writeM) && ($urandom_range(1, 0) == 1 || !i_readM)) begin
        d_address = 16'($urandom);
        d_wdata   = {$urandom, $urandom};
        if ($urandom_range(1, 0) == 1) d_writeM = 1; else d_readM = 1;
      end
      serve($urandom_range(5, 1), {$urandom, $urandom}, g);
    end
  endtask

  initial begin
    test_reset();
    test_i_only();
    test_ignore_done();
    test_collision();
    test_starvation();
    test_write();
    test_reset_midop();
    test_stats();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
